// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared types and constants for the multiplexed 7-segment
//                driver. Symbol codes, active-low segment patterns (g..a)
//                and the scan-state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package sseg_pkg;

    // Width of one symbol code. The top-level SYM_W parameter must match it.
    localparam int unsigned SYM_BITS = 5;

    // SYM_D_HEX is the hex digit 'd'; SYM_D is the drive-gear letter. Both
    // render identically but are kept apart so status logic can name intent.
    typedef enum logic [SYM_BITS-1:0] {
        SYM_0     = 5'd0,
        SYM_1     = 5'd1,
        SYM_2     = 5'd2,
        SYM_3     = 5'd3,
        SYM_4     = 5'd4,
        SYM_5     = 5'd5,
        SYM_6     = 5'd6,
        SYM_7     = 5'd7,
        SYM_8     = 5'd8,
        SYM_9     = 5'd9,
        SYM_A     = 5'd10,
        SYM_B     = 5'd11,
        SYM_C     = 5'd12,
        SYM_D_HEX = 5'd13,
        SYM_E     = 5'd14,
        SYM_F     = 5'd15,
        SYM_D     = 5'd16,
        SYM_N     = 5'd17,
        SYM_R     = 5'd18,
        SYM_P     = 5'd19,
        SYM_DASH  = 5'd20,
        SYM_BLANK = 5'd31
    } sym_t;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/sseg_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_decoder
//  Description : Combinational symbol -> active-low 7-segment pattern.
//                Unknown / unused codes render blank.
//  Ports       : i_sym  symbol code
//                o_seg  segments g..a, active-low
//  Revision    : 1.0  initial release
// ============================================================================
module sseg_decoder
    import sseg_pkg::*;
(
    input  sym_t       i_sym,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_sym)
            SYM_0:     o_seg = 7'b1000000;
            SYM_1:     o_seg = 7'b1111001;
            SYM_2:     o_seg = 7'b0100100;
            SYM_3:     o_seg = 7'b0110000;
            SYM_4:     o_seg = 7'b0011001;
            SYM_5:     o_seg = 7'b0010010;
            SYM_6:     o_seg = 7'b0000010;
            SYM_7:     o_seg = 7'b1111000;
            SYM_8:     o_seg = 7'b0000000;
            SYM_9:     o_seg = 7'b0010000;
            SYM_A:     o_seg = 7'b0001000;
            SYM_B:     o_seg = 7'b0000011;
            SYM_C:     o_seg = 7'b1000110;
            SYM_D_HEX: o_seg = SEG_D;
            SYM_E:     o_seg = 7'b0000110;
            SYM_F:     o_seg = 7'b0001110;
            SYM_D:     o_seg = SEG_D;
            SYM_N:     o_seg = SEG_N;
            SYM_R:     o_seg = SEG_R;
            SYM_P:     o_seg = SEG_P;
            SYM_DASH:  o_seg = SEG_DASH;
            default:   o_seg = SEG_BLANK;
        endcase
    end

endmodule : sseg_decoder
`default_nettype wire

// File: rtl/sseg_mux_drv.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_mux_drv
//  Description : Time-multiplexed 7-segment driver with a double-buffered
//                frame (valid/ready load, swap only at frame wrap),
//                anti-ghosting blank at the start of every digit slot and
//                per-digit blink.
//  Ports       : clk, rst_n        clock, asynchronous active-low reset
//                i_frame_valid     new frame offered
//                o_frame_ready     frame accepted when valid is also high
//                i_frame_sym       DIGITS symbols, digit 0 in the LSBs
//                i_frame_blink     per-digit blink enable
//                i_frame_dp        per-digit decimal point
//                o_an              anodes, active-low
//                o_char            segments g..a, active-low
//                o_dp              decimal point, active-low
//                o_frame_sync      high on the cycle whose edge swaps frames
//  Revision    : 1.0  initial release
// ============================================================================
module sseg_mux_drv
    import sseg_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_HZ     = 2,
    parameter int unsigned SYM_W        = 5
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_frame_valid,
    output logic                    o_frame_ready,
    input  logic [DIGITS*SYM_W-1:0] i_frame_sym,
    input  logic [DIGITS-1:0]       i_frame_blink,
    input  logic [DIGITS-1:0]       i_frame_dp,
    output logic [DIGITS-1:0]       o_an,
    output logic [6:0]              o_char,
    output logic                    o_dp,
    output logic                    o_frame_sync
);

    localparam int unsigned SLOT_DIV  = CLK_HZ / (REFRESH_HZ * DIGITS);
    localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned SLOT_W    = (SLOT_DIV  > 1) ? $clog2(SLOT_DIV)  : 1;
    localparam int unsigned DIG_W     = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
    localparam int unsigned BLK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    if (SLOT_DIV <= BLANK_CYCLES) begin : g_err_slot_div
        $error("sseg_mux_drv: SLOT_DIV must exceed BLANK_CYCLES");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_err_digits
        $error("sseg_mux_drv: DIGITS must be 1..8");
    end
    if (SYM_W != SYM_BITS) begin : g_err_sym_w
        $error("sseg_mux_drv: SYM_W must match the package symbol width");
    end
    if (BLINK_DIV < 1) begin : g_err_blink_div
        $error("sseg_mux_drv: BLINK_DIV must be at least 1");
    end

    // ---------------- scan counters ----------------
    logic [SLOT_W-1:0] r_slot;
    logic [DIG_W-1:0]  r_digit;
    scan_state_t       r_state;
    logic              r_ready;

    logic              w_slot_last;
    logic              w_dig_last;
    logic              w_wrap;
    logic [SLOT_W-1:0] w_slot_nxt;
    logic [DIG_W-1:0]  w_digit_nxt;

    assign w_slot_last = (r_slot  == SLOT_W'(SLOT_DIV - 1));
    assign w_dig_last  = (r_digit == DIG_W'(DIGITS - 1));
    assign w_wrap      = w_slot_last && w_dig_last;
    assign w_slot_nxt  = w_slot_last ? '0 : r_slot + 1'b1;
    assign w_digit_nxt = !w_slot_last ? r_digit :
                         (w_dig_last ? '0 : r_digit + 1'b1);

    // ---------------- frame buffers ----------------
    sym_t              r_act_sym  [DIGITS];
    sym_t              r_pend_sym [DIGITS];
    logic [DIGITS-1:0] r_act_blink, r_pend_blink;
    logic [DIGITS-1:0] r_act_dp,    r_pend_dp;
    logic              r_pend_flag;
    logic              w_xfer;

    assign w_xfer = i_frame_valid && r_ready;

    // Non-blocking semantics make a transfer on the swap edge land in
    // pending while active takes the previous pending contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_act_sym[i]  <= SYM_BLANK;
                r_pend_sym[i] <= SYM_BLANK;
            end
            r_act_blink  <= '0;
            r_pend_blink <= '0;
            r_act_dp     <= '0;
            r_pend_dp    <= '0;
            r_pend_flag  <= 1'b0;
        end else begin
            if (w_wrap && r_pend_flag) begin
                r_act_sym   <= r_pend_sym;
                r_act_blink <= r_pend_blink;
                r_act_dp    <= r_pend_dp;
            end
            if (w_xfer) begin
                for (int i = 0; i < DIGITS; i++) begin
                    r_pend_sym[i] <= sym_t'(i_frame_sym[i*SYM_W +: SYM_W]);
                end
                r_pend_blink <= i_frame_blink;
                r_pend_dp    <= i_frame_dp;
            end
            r_pend_flag <= w_xfer || (r_pend_flag && !w_wrap);
        end
    end

    // ---------------- blink phase ----------------
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink_hidden;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt    <= '0;
            r_blink_hidden <= 1'b0;
        end else if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt    <= '0;
            r_blink_hidden <= !r_blink_hidden;
        end else begin
            r_blink_cnt    <= r_blink_cnt + 1'b1;
        end
    end

    // ---------------- symbol mux and decode ----------------
    sym_t              w_sym;
    logic [6:0]        w_seg;
    logic [DIGITS-1:0] w_an;
    logic              w_hide;

    assign w_sym  = r_act_sym[r_digit];
    assign w_an   = ~(DIGITS'(1) << r_digit);
    assign w_hide = r_act_blink[r_digit] && r_blink_hidden;

    sseg_decoder u_decoder (
        .i_sym (w_sym),
        .o_seg (w_seg)
    );

    // ---------------- scan FSM with registered outputs ----------------
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_char;
    logic              r_dp;
    logic              r_frame_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot       <= '0;
            r_digit      <= '0;
            r_state      <= (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;
            r_ready      <= 1'b0;
            r_an         <= '1;
            r_char       <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_sync <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_slot  <= w_slot_nxt;
            r_digit <= w_digit_nxt;
            r_state <= (w_slot_nxt < SLOT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
            // Flag the cycle whose closing edge performs the frame swap.
            r_frame_sync <= (w_slot_nxt  == SLOT_W'(SLOT_DIV - 1)) &&
                            (w_digit_nxt == DIG_W'(DIGITS - 1));
            case (r_state)
                ST_DRIVE: begin
                    r_an <= w_an;
                    if (w_hide) begin
                        r_char <= SEG_BLANK;
                        r_dp   <= 1'b1;
                    end else begin
                        r_char <= w_seg;
                        r_dp   <= !r_act_dp[r_digit];
                    end
                end
                default: begin
                    r_an   <= '1;
                    r_char <= SEG_BLANK;
                    r_dp   <= 1'b1;
                end
            endcase
        end
    end

    assign o_frame_ready = r_ready;
    assign o_an          = r_an;
    assign o_char        = r_char;
    assign o_dp          = r_dp;
    assign o_frame_sync  = r_frame_sync;

endmodule : sseg_mux_drv
`default_nettype wire

// File: tb/tb_sseg_mux_drv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_mux_drv
//  Description : Directed self-checking bench for sseg_mux_drv with
//                DIGITS=4, SLOT_DIV=5, BLANK_CYCLES=1, BLINK_DIV=100.
//                Every cycle's outputs are compared to the scan timing and
//                the frame the bench expects to be active.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sseg_mux_drv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_valid;
    logic        frame_ready;
    logic [19:0] frame_sym;
    logic [3:0]  frame_blink;
    logic [3:0]  frame_dp;
    logic [3:0]  an;
    logic [6:0]  char_o;
    logic        dp_o;
    logic        sync;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;   // rising edges since the last reset release

    // Expected active / pending / staged frame contents.
    logic [6:0] cur_seg [4];
    logic [6:0] pend_seg[4];
    logic [6:0] stg_seg [4];
    logic [3:0] cur_blink, pend_blink, stg_blink;
    logic [3:0] cur_dp,    pend_dp,    stg_dp;

    always #5 clk = ~clk;

    sseg_mux_drv #(
        .DIGITS       (4),
        .CLK_HZ       (1000),
        .REFRESH_HZ   (50),
        .BLANK_CYCLES (1),
        .BLINK_HZ     (5),
        .SYM_W        (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_valid (frame_valid),
        .o_frame_ready (frame_ready),
        .i_frame_sym   (frame_sym),
        .i_frame_blink (frame_blink),
        .i_frame_dp    (frame_dp),
        .o_an          (an),
        .o_char        (char_o),
        .o_dp          (dp_o),
        .o_frame_sync  (sync)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (k=%0d): got 0x%0h, expected 0x%0h", tag, k, got, exp);
        end
    endtask

    // Hand-entered active-low patterns (g..a) for the codes used here.
    function automatic logic [6:0] seg_of(input int code);
        case (code)
            0:  return 7'h40;
            1:  return 7'h79;
            2:  return 7'h24;
            3:  return 7'h30;
            4:  return 7'h19;
            5:  return 7'h12;
            6:  return 7'h02;
            7:  return 7'h78;
            8:  return 7'h00;
            9:  return 7'h10;
            16: return 7'b0100001;
            17: return 7'b0101011;
            18: return 7'b0101111;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 4; i++) begin
            cur_seg[i]  = 7'h7F;
            pend_seg[i] = 7'h7F;
        end
        cur_blink = '0; pend_blink = '0;
        cur_dp    = '0; pend_dp    = '0;
    endtask

    // One clock: outputs after edge k reflect counter index c = k-1.
    task automatic step(input bit do_xfer);
        int         c, slot, dig;
        logic [3:0] ea;
        logic [6:0] ec;
        logic       ed;
        @(posedge clk);
        #1;
        k++;
        c    = k - 1;
        slot = c % 5;
        dig  = (c / 5) % 4;
        if (slot == 0) begin
            ea = 4'hF; ec = 7'h7F; ed = 1'b1;
        end else begin
            ea = ~(4'b0001 << dig);
            if (cur_blink[dig] && ((c / 100) % 2 == 1)) begin
                ec = 7'h7F; ed = 1'b1;
            end else begin
                ec = cur_seg[dig]; ed = ~cur_dp[dig];
            end
        end
        check_eq("an",    an,          ea);
        check_eq("char",  char_o,      ec);
        check_eq("dp",    dp_o,        ed);
        check_eq("sync",  sync,        (k % 20 == 19));
        check_eq("ready", frame_ready, 1'b1);
        if (k % 20 == 0) begin
            cur_seg = pend_seg; cur_blink = pend_blink; cur_dp = pend_dp;
        end
        if (do_xfer) begin
            pend_seg = stg_seg; pend_blink = stg_blink; pend_dp = stg_dp;
        end
    endtask

    task automatic xfer(input int s3, input int s2, input int s1, input int s0,
                        input logic [3:0] bl, input logic [3:0] dpv);
        frame_sym   = {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
        frame_blink = bl;
        frame_dp    = dpv;
        frame_valid = 1'b1;
        stg_seg[3] = seg_of(s3); stg_seg[2] = seg_of(s2);
        stg_seg[1] = seg_of(s1); stg_seg[0] = seg_of(s0);
        stg_blink = bl; stg_dp = dpv;
        step(1'b1);
        frame_valid = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (k < target) step(1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        rst_n       = 1'b0;
        frame_valid = 1'b0;
        frame_sym   = '1;
        frame_blink = '0;
        frame_dp    = '0;
        reset_model();

        // 1. reset, then idle blank scanning
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_an",    an,          4'hF);
        check_eq("rst_char",  char_o,      7'h7F);
        check_eq("rst_dp",    dp_o,        1'b1);
        check_eq("rst_ready", frame_ready, 1'b0);
        check_eq("rst_sync",  sync,        1'b0);
        #3 rst_n = 1'b1;
        run_to(40);

        // 2. load {R,N,D,BLANK}; visible only after the next swap
        xfer(18, 17, 16, 31, 4'b0000, 4'b0000);
        run_to(100);

        // 3. two transfers in one frame: last one wins
        run_to(105);
        xfer(1, 2, 3, 4, 4'b0000, 4'b0000);
        run_to(110);
        xfer(5, 6, 7, 8, 4'b0000, 4'b0000);
        hits = 0;
        while (k < 160) begin
            step(1'b0);
            if (char_o inside {7'h79, 7'h24, 7'h30, 7'h19}) hits++;
        end
        check_eq("no_1234_seen", hits, 0);

        // 4. transfer on the frame_sync cycle
        run_to(164);
        xfer(16, 9, 0, 17, 4'b0000, 4'b0000);
        run_to(179);
        check_eq("sync_at_swap", sync, 1'b1);
        xfer(3, 3, 5, 18, 4'b0000, 4'b0000);
        run_to(230);

        // 5. blink on digit2 (N), dp on digit0
        xfer(9, 17, 7, 0, 4'b0100, 4'b0001);
        run_to(460);

        // 6. asynchronous reset at slot_cnt=3 of digit2
        while (k % 20 != 13) step(1'b0);
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_an",    an,          4'hF);
        check_eq("mid_rst_char",  char_o,      7'h7F);
        check_eq("mid_rst_dp",    dp_o,        1'b1);
        check_eq("mid_rst_ready", frame_ready, 1'b0);
        check_eq("mid_rst_sync",  sync,        1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        reset_model();
        run_to(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sseg_mux_drv
`default_nettype wire
